// File: rtl/cpu_pkg.sv
// Shared control-unit data-path types and widths (register block, ALU, data memory).
// Types only; no latency, no flow control.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_BAD = 2'd2
  } dm_op_t;

  function automatic dm_op_t decode_op(input logic rd, input logic wr);
    if (rd && !wr) return OP_RD;
    if (wr && !rd) return OP_WR;
    return OP_BAD;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory strobe interface between the control unit and the memory responder.
// No latency of its own; the control unit must hold off new strobes until d_done.
interface data_mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              m_r;
  logic              m_w;
  logic              d_act;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] m_out;
  logic              d_done;
  logic              d_busy;
  logic              d_err;

  modport master (
    output addr, m_r, m_w, d_act, d_in,
    input  m_out, d_done, d_busy, d_err
  );

  modport slave (
    input  addr, m_r, m_w, d_act, d_in,
    output m_out, d_done, d_busy, d_err
  );
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage: synchronous write, registered synchronous read, async clear.
// One-cycle read latency; no backpressure.
module data_mem_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              core_clk,
  input  logic              arst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_dat,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_dat <= '0;
    end else begin
      if (wr_en) mem[addr] <= wr_dat;
      if (rd_en) rd_dat <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request in flight, access LATENCY edges after acceptance, d_done pulse after.
// Strobes arriving while a request is waiting are dropped; all outputs are registered.
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int LATENCY = 2
) (
  input logic                  core_clk,
  input logic                  arst_n,
  data_mem_responder_if.slave  bus
);

  dm_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  dm_op_t            op_q;
  logic              accept;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_dat;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      op_q    <= OP_RD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= bus.addr;
        din_q  <= bus.d_in;
        op_q   <= decode_op(bus.m_r, bus.m_w);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (bus.d_act) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Strobes seen here are deliberately ignored: the in-flight request owns the latches.
        if (cnt_q == '0) begin
          wr_en   = (op_q == OP_WR);
          rd_en   = (op_q == OP_RD);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .core_clk (core_clk),
    .arst_n   (arst_n),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr_q),
    .wr_dat   (din_q),
    .rd_dat   (rd_dat)
  );

  assign bus.m_out  = rd_dat;
  assign bus.d_done = (state_q == RESP);
  assign bus.d_busy = (state_q != IDLE);
  assign bus.d_err  = (state_q == RESP) && (op_q == OP_BAD);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=2 with hand-computed expectations.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic core_clk = 1'b0;
  logic arst_n   = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   cyc      = 0;

  data_mem_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  data_mem_responder #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .LATENCY(LAT)) dut (
    .core_clk (core_clk),
    .arst_n   (arst_n),
    .bus      (bus)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request and waits for its d_done; leaves time inside the RESP cycle.
  task automatic do_req(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] out, output logic err, output int done_cyc);
    @(negedge core_clk);
    bus.m_r = r; bus.m_w = w; bus.addr = a; bus.d_in = d; bus.d_act = 1'b1;
    @(posedge core_clk);
    #1 bus.d_act = 1'b0;
    lat = -1; out = 'x; err = 1'bx; done_cyc = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge core_clk);
      #1;
      if (bus.d_done) begin
        lat = n; out = bus.m_out; err = bus.d_err; done_cyc = cyc;
        break;
      end
    end
  endtask

  int         lat, dc1, dc2, ndone;
  logic [7:0] out;
  logic       err;

  initial begin
    bus.addr = '0; bus.m_r = 1'b0; bus.m_w = 1'b0; bus.d_act = 1'b0; bus.d_in = '0;
    repeat (2) @(negedge core_clk);
    chk("rst_m_out", bus.m_out, 0);
    chk("rst_done", bus.d_done, 0);
    chk("rst_busy", bus.d_busy, 0);
    chk("rst_err", bus.d_err, 0);
    arst_n = 1'b1;

    do_req(1, 0, 4'd5, 8'h00, lat, out, err, dc1);
    chk("rd5_lat", lat, LAT);
    chk("rd5_data", out, 8'h00);
    chk("rd5_err", err, 0);

    do_req(0, 1, 4'd3, 8'hA5, lat, out, err, dc1);
    chk("wr3_lat", lat, LAT);
    chk("wr3_err", err, 0);
    do_req(1, 0, 4'd3, 8'h00, lat, out, err, dc1);
    chk("rd3_lat", lat, LAT);
    chk("rd3_data", out, 8'hA5);
    @(posedge core_clk); #1;
    chk("done_pulse_width", bus.d_done, 0);
    chk("busy_after_done", bus.d_busy, 0);

    // Second request is strobed during the first one's RESP cycle.
    do_req(0, 1, 4'd15, 8'hFE, lat, out, err, dc1);
    chk("wr15_m_out_held", out, 8'hA5);
    do_req(1, 0, 4'd15, 8'h00, lat, out, err, dc2);
    chk("b2b_spacing", dc2 - dc1, LAT + 1);
    chk("rd15_data", out, 8'hFE);

    do_req(1, 1, 4'd3, 8'h5A, lat, out, err, dc1);
    chk("bad_lat", lat, LAT);
    chk("bad_err", err, 1);
    chk("bad_m_out_held", out, 8'hFE);
    do_req(1, 0, 4'd3, 8'h00, lat, out, err, dc1);
    chk("rd3_after_bad", out, 8'hA5);
    chk("rd3_after_bad_err", err, 0);

    // Busy drop: second strobe lands one edge after acceptance, inside WAIT.
    @(negedge core_clk);
    bus.m_r = 0; bus.m_w = 1; bus.addr = 4'd1; bus.d_in = 8'h11; bus.d_act = 1;
    @(negedge core_clk);
    chk("busy_in_wait", bus.d_busy, 1);
    bus.addr = 4'd2; bus.d_in = 8'h22;
    @(negedge core_clk);
    bus.d_act = 0;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge core_clk);
      if (bus.d_done) ndone++;
    end
    chk("drop_done_count", ndone, 1);
    do_req(1, 0, 4'd2, 8'h00, lat, out, err, dc1);
    chk("rd2_dropped", out, 8'h00);
    do_req(1, 0, 4'd1, 8'h00, lat, out, err, dc1);
    chk("rd1_kept", out, 8'h11);

    // Reset during WAIT of a write: everything clears and the write never lands.
    @(negedge core_clk);
    bus.m_r = 0; bus.m_w = 1; bus.addr = 4'd4; bus.d_in = 8'h77; bus.d_act = 1;
    @(posedge core_clk);
    #1 bus.d_act = 0;
    #2 arst_n = 1'b0;
    #1;
    chk("mid_rst_m_out", bus.m_out, 0);
    chk("mid_rst_busy", bus.d_busy, 0);
    chk("mid_rst_done", bus.d_done, 0);
    chk("mid_rst_err", bus.d_err, 0);
    repeat (2) @(negedge core_clk);
    arst_n = 1'b1;
    do_req(1, 0, 4'd4, 8'h00, lat, out, err, dc1);
    chk("rd4_after_rst_lat", lat, LAT);
    chk("rd4_after_rst", out, 8'h00);
    do_req(1, 0, 4'd1, 8'h00, lat, out, err, dc1);
    chk("rd1_after_rst", out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
